// File: rtl/ec_pkg.sv
// Shared definitions for the EC datapath blocks.
//   EC_OPERAND_W : default field-operand width
//   ec_operand_t : signed operand at the default width
//   clog2        : index width for a count, never less than 1
package ec_pkg;

  localparam int EC_OPERAND_W = 256;

  typedef logic signed [EC_OPERAND_W-1:0] ec_operand_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/sum_select_pipe_if.sv
// Handshake bundle for sum_select_pipe.
//   in_data/in_valid/in_ready : NUM_IN packed input channels
//   mode/select               : channel choice control (0 = directed, 1 = round-robin)
//   out_data/out_valid/out_ready/out_chan : registered output stage
//   sel_err                   : sticky out-of-range directed select flag
// master = the side that supplies operands and consumes the output; slave = the selector.
interface sum_select_pipe_if #(
  parameter int WIDTH  = ec_pkg::EC_OPERAND_W,
  parameter int NUM_IN = 4
);
  import ec_pkg::*;

  localparam int SEL_W = clog2(NUM_IN);

  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_ready;
  logic                    mode;
  logic [SEL_W-1:0]        select;
  logic signed [WIDTH-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [SEL_W-1:0]        out_chan;
  logic                    sel_err;

  modport master (
    output in_data, in_valid, mode, select, out_ready,
    input  in_ready, out_data, out_valid, out_chan, sel_err
  );

  modport slave (
    input  in_data, in_valid, mode, select, out_ready,
    output in_ready, out_data, out_valid, out_chan, sel_err
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority arbiter.
//   req     : request vector, N bits
//   ptr     : index of the last winner; it gets the lowest priority
//   gnt_idx : first requester scanning ptr+1, ptr+2, ... (mod N), ptr last
//   gnt_any : at least one request present
module rr_arbiter
  import ec_pkg::*;
#(
  parameter int N = 4,
  localparam int PW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] gnt_idx,
  output logic          gnt_any
);

  // Walk from the farthest position back to the nearest so that the
  // closest requester after ptr is the last one to overwrite the result.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = N; k >= 1; k--) begin
      idx = int'((32'(ptr) + 32'(k)) % 32'(N));
      if (req[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/sum_select_pipe.sv
// Registered N-to-1 operand selector with valid/ready handshake.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : sum_select_pipe_if slave port (inputs, control, output stage, sel_err)
// One operand per cycle moves from the granted channel into the output
// register; the channel is picked by explicit select or round-robin.
module sum_select_pipe
  import ec_pkg::*;
#(
  parameter int WIDTH  = EC_OPERAND_W,
  parameter int NUM_IN = 4
) (
  input  logic             clk,
  input  logic             rst,
  sum_select_pipe_if.slave bus
);

  localparam int SEL_W = clog2(NUM_IN);
  localparam int PAD_N = 1 << SEL_W;
  localparam logic [SEL_W:0] NUM_IN_W = (SEL_W+1)'(NUM_IN);

  logic [SEL_W-1:0]  rr_ptr;
  logic [SEL_W-1:0]  arb_idx;
  logic              arb_any;
  logic [PAD_N-1:0]  valid_pad;
  logic              sel_bad;
  logic              dir_any;
  logic [SEL_W-1:0]  gnt_idx;
  logic              gnt_any;
  logic              slot;
  logic              xfer;
  logic [NUM_IN-1:0] in_ready_c;
  logic [WIDTH-1:0]  gnt_data;

  logic [WIDTH-1:0]  out_data_q;
  logic              out_valid_q;
  logic [SEL_W-1:0]  out_chan_q;
  logic              sel_err_q;

  // Padding lets an out-of-range select index the valid vector safely.
  assign valid_pad = PAD_N'(bus.in_valid);
  assign sel_bad   = {1'b0, bus.select} >= NUM_IN_W;
  assign dir_any   = !sel_bad && valid_pad[bus.select];

  rr_arbiter #(.N(NUM_IN)) u_arb (
    .req     (bus.in_valid),
    .ptr     (rr_ptr),
    .gnt_idx (arb_idx),
    .gnt_any (arb_any)
  );

  assign gnt_any = bus.mode ? arb_any : dir_any;
  assign gnt_idx = bus.mode ? arb_idx : bus.select;
  assign slot    = !out_valid_q || bus.out_ready;
  assign xfer    = slot && gnt_any;

  always_comb begin
    in_ready_c = '0;
    gnt_data   = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (gnt_idx == SEL_W'(i)) begin
        in_ready_c[i] = xfer;
        gnt_data      = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      sel_err_q   <= 1'b0;
      rr_ptr      <= SEL_W'(NUM_IN - 1);
    end else begin
      if (xfer) begin
        out_data_q  <= gnt_data;
        out_chan_q  <= gnt_idx;
        out_valid_q <= 1'b1;
        // Pointer follows every transfer so mode switches keep fairness history.
        rr_ptr      <= gnt_idx;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (!bus.mode && sel_bad) sel_err_q <= 1'b1;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.sel_err   = sel_err_q;

endmodule
